// File: rtl/c_requant_unit.sv
// Requantizes C-buffer rows (four int32 accumulators) into packed int8 words and
// streams them out on a valid/ready interface, one row per word, in index order.

module c_requant_lane (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic signed [31:0] lane,
   input  logic signed [31:0] bias,
   input  logic signed [31:0] mult,
   input  logic        [4:0]  shift,
   input  logic signed [7:0]  out_offset,
   input  logic signed [7:0]  act_min,
   input  logic signed [7:0]  act_max,
   output logic        [7:0]  result
);

   logic signed [31:0] a;
   logic signed [63:0] prod;
   logic        [6:0]  rnd_sh;
   logic signed [64:0] biased;
   logic signed [64:0] shifted;
   logic signed [64:0] v;

   assign a = lane + bias;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   prod <= '0;
      else if (en) prod <= 64'(a) * 64'(mult);
   end

   // Rounding constant and shift share one amount so round-half-up stays exact.
   always_comb begin
      rnd_sh  = 7'd30 + 7'(shift);
      biased  = 65'(prod) + (65'sd1 <<< rnd_sh);
      shifted = biased >>> (rnd_sh + 7'd1);
      v       = shifted + 65'(out_offset);
      if (v < 65'(act_min))      result = act_min;
      else if (v > 65'(act_max)) result = act_max;
      else                       result = v[7:0];
   end

endmodule

module c_requant_unit #(
   parameter int C_ADDR_BITS = 16,
   parameter int C_DATA_BITS = 128,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [C_ADDR_BITS-1:0] base,
   input  logic [C_ADDR_BITS-1:0] count,
   input  logic [31:0]            bias,
   input  logic [31:0]            mult,
   input  logic [4:0]             shift,
   input  logic [7:0]             out_offset,
   input  logic [7:0]             act_min,
   input  logic [7:0]             act_max,
   output logic                   c_rd_en,
   output logic [C_ADDR_BITS-1:0] c_index,
   input  logic [C_DATA_BITS-1:0] c_data_out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_data,
   output logic [C_ADDR_BITS-1:0] out_index,
   output logic                   busy,
   output logic                   done
);

   localparam int STAGES    = 2;
   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 32;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int OCC_W     = PTR_W + 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [C_ADDR_BITS-1:0] base;
      logic [C_ADDR_BITS-1:0] count;
      logic [31:0]            bias;
      logic [31:0]            mult;
      logic [4:0]             shift;
      logic [7:0]             out_offset;
      logic [7:0]             act_min;
      logic [7:0]             act_max;
   } job_t;

   typedef struct packed {
      logic [C_ADDR_BITS-1:0] index;
      logic [31:0]            data;
   } word_t;

   state_t                            state, state_nxt;
   job_t                              job;
   logic [C_ADDR_BITS-1:0]            issued;
   logic [STAGES:1]                   vld_q;
   logic [STAGES:0]                   vld_pipe;
   logic [STAGES:1][C_ADDR_BITS-1:0]  idx_q;
   logic [NUM_LANES-1:0][LANE_W-1:0]  lanes;
   logic [NUM_LANES-1:0][7:0]         res;
   logic [31:0]                       word_data;

   word_t                             mem [FIFO_DEPTH];
   logic [PTR_W-1:0]                  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]                  fifo_cnt;
   logic                              push, pop;
   logic [OCC_W-1:0]                  occ;
   logic                              credit;
   logic                              drain_ok;

   assign vld_pipe = {vld_q, c_rd_en};
   assign c_index  = job.base + issued;
   assign push     = vld_pipe[STAGES];
   assign pop      = out_valid && out_ready;

   // Credit counts every read still in the pipe plus every queued word, so the
   // FIFO can absorb all in-flight results even with the consumer stalled.
   always_comb begin
      occ = OCC_W'(fifo_cnt);
      for (int s = 1; s <= STAGES; s++) occ = occ + OCC_W'(vld_q[s]);
      credit = occ < OCC_W'(FIFO_DEPTH);
   end

   // Finish in the cycle the last word leaves so done follows the handshake directly.
   assign drain_ok = (vld_q == '0) &&
                     ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop));

   always_comb begin
      state_nxt = state;
      c_rd_en   = 1'b0;
      busy      = (state == RUN) || (state == DRAIN);
      done      = (state == DONE);
      case (state)
         IDLE:  if (start) state_nxt = RUN;
         RUN: begin
            if (issued == job.count) begin
               state_nxt = DRAIN;
            end else if (credit) begin
               c_rd_en = 1'b1;
               if (issued + C_ADDR_BITS'(1) == job.count) state_nxt = DRAIN;
            end
         end
         DRAIN: if (drain_ok) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         job    <= '0;
         issued <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            job    <= '{base: base, count: count, bias: bias, mult: mult, shift: shift,
                        out_offset: out_offset, act_min: act_min, act_max: act_max};
            issued <= '0;
         end else if (c_rd_en) begin
            issued <= issued + C_ADDR_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         idx_q <= '0;
      end else begin
         vld_q    <= vld_pipe[STAGES-1:0];
         idx_q[1] <= c_index;
         for (int s = 2; s <= STAGES; s++) idx_q[s] <= idx_q[s-1];
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lanes[i] = c_data_out[C_DATA_BITS-1-LANE_W*i -: LANE_W];
      assign word_data[31-8*i -: 8] = res[i];

      c_requant_lane u_lane (
         .clk        (clk),
         .reset      (reset),
         .en         (vld_pipe[1]),
         .lane       (lanes[i]),
         .bias       (job.bias),
         .mult       (job.mult),
         .shift      (job.shift),
         .out_offset (job.out_offset),
         .act_min    (job.act_min),
         .act_max    (job.act_max),
         .result     (res[i])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{index: idx_q[STAGES], data: word_data};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   assign out_valid = (fifo_cnt != '0);
   assign out_data  = mem[rd_ptr].data;
   assign out_index = mem[rd_ptr].index;

endmodule

// File: tb/tb_c_requant_unit.sv
// Scoreboard bench for c_requant_unit: expected words are queued at job launch
// and compared against every output handshake.

module tb_c_requant_unit;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [15:0]  base, count;
   logic [31:0]  bias, mult;
   logic [4:0]   shift;
   logic [7:0]   out_offset, act_min, act_max;
   logic         c_rd_en;
   logic [15:0]  c_index;
   logic [127:0] c_data_out = '0;
   logic         out_valid, out_ready;
   logic [31:0]  out_data;
   logic [15:0]  out_index;
   logic         busy, done;

   typedef struct packed {
      logic [15:0] idx;
      logic [31:0] data;
   } exp_t;

   exp_t         exp_q[$];
   logic [31:0]  got_q[$];
   int           hs_cyc[$];
   logic [127:0] cmem [int];

   int checks = 0, failures = 0, cyc = 0;
   int first_rd_cyc = -1, first_val_cyc = -1;
   int rd_cnt = 0, acc_cnt = 0, max_outst = 0;
   int done_cnt = 0, done_cyc = 0, start_cyc = 0;

   c_requant_unit #(.C_ADDR_BITS(16), .C_DATA_BITS(128), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
      .bias(bias), .mult(mult), .shift(shift), .out_offset(out_offset),
      .act_min(act_min), .act_max(act_max), .c_rd_en(c_rd_en), .c_index(c_index),
      .c_data_out(c_data_out), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_index(out_index), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] row(input logic [15:0] idx);
      if (cmem.exists(int'(idx))) return cmem[int'(idx)];
      return '0;
   endfunction

   function automatic logic [7:0] ref_lane(input logic [31:0] x, b, m, input logic [4:0] sh,
                                           input logic [7:0] off, mn, mx);
      logic signed [31:0] a;
      longint p, r, v;
      a = $signed(x + b);
      p = longint'(a) * longint'($signed(m));
      r = (p + (longint'(1) <<< (30 + int'(sh)))) >>> (31 + int'(sh));
      v = r + longint'($signed(off));
      if (v < longint'($signed(mn)))      v = longint'($signed(mn));
      else if (v > longint'($signed(mx))) v = longint'($signed(mx));
      return v[7:0];
   endfunction

   function automatic logic [31:0] ref_word(input logic [127:0] r, input logic [31:0] b, m,
                                            input logic [4:0] sh, input logic [7:0] off, mn, mx);
      logic [31:0] w;
      for (int i = 0; i < 4; i++)
         w[31-8*i -: 8] = ref_lane(r[127-32*i -: 32], b, m, sh, off, mn, mx);
      return w;
   endfunction

   // C buffer model: one-cycle read latency
   initial forever begin
      @(posedge clk);
      cyc++;
      if (c_rd_en) c_data_out <= row(c_index);
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!reset) begin
         if (c_rd_en) begin
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
         end
         if (rd_cnt - acc_cnt > max_outst) max_outst = rd_cnt - acc_cnt;
         if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
         if (out_valid && out_ready) begin
            chk("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("word_data", out_data, e.data);
               chk("word_index", out_index, e.idx);
            end
            got_q.push_back(out_data);
            hs_cyc.push_back(cyc);
            acc_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic fill_rand(input logic [15:0] b, input int n);
      logic [15:0] idx;
      for (int k = 0; k < n; k++) begin
         idx = b + 16'(k);
         cmem[int'(idx)] = {32'($urandom_range(0, 200000)) - 32'd100000, $urandom,
                            32'($urandom_range(0, 4000)) - 32'd2000, 32'($urandom_range(0, 255))};
      end
   endtask

   task automatic push_exp(input logic [15:0] b, input int n, input logic [31:0] bi, mu,
                           input logic [4:0] sh, input logic [7:0] off, mn, mx);
      logic [15:0] idx;
      for (int k = 0; k < n; k++) begin
         idx = b + 16'(k);
         exp_q.push_back('{idx: idx, data: ref_word(row(idx), bi, mu, sh, off, mn, mx)});
      end
   endtask

   task automatic set_job(input logic [15:0] b, n, input logic [31:0] bi, mu,
                          input logic [4:0] sh, input logic [7:0] off, mn, mx);
      base = b; count = n; bias = bi; mult = mu; shift = sh;
      out_offset = off; act_min = mn; act_max = mx;
   endtask

   // mode 0: out_ready held high; mode 1: ready one cycle in three
   task automatic run_job(input logic [15:0] b, n, input logic [31:0] bi, mu,
                          input logic [4:0] sh, input logic [7:0] off, mn, mx,
                          input int mode, input bit poke);
      int d0, i;
      got_q.delete(); hs_cyc.delete();
      first_rd_cyc = -1; first_val_cyc = -1;
      rd_cnt = 0; acc_cnt = 0; max_outst = 0;
      push_exp(b, int'(n), bi, mu, sh, off, mn, mx);
      @(posedge clk); #1;
      set_job(b, n, bi, mu, sh, off, mn, mx);
      start = 1'b1;
      out_ready = (mode == 0);
      start_cyc = cyc;
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b0;
      i = 0;
      while (done_cnt == d0 && i < 3000) begin
         start = 1'b0;
         if (poke && i == 4) begin
            start = 1'b1;
            set_job(b + 16'd3, 16'd2, bi ^ 32'h55, mu + 32'd7, sh + 5'd1, off + 8'd5, 8'h00, 8'h10);
         end
         out_ready = (mode == 0) ? 1'b1 : (i % 3 == 0);
         @(posedge clk); #1;
         i++;
      end
      start = 1'b0;
      chk("done_seen", done_cnt != d0, 1);
      chk("sb_drained", exp_q.size(), 0);
      chk("word_count", got_q.size(), 64'(n));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      set_job('0, '0, '0, '0, '0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_en", c_rd_en, 0);
      chk("rst_c_index", c_index, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;

      // single row
      cmem[16'h0040] = {4{32'd100}};
      run_job(16'h0040, 16'd1, 32'd0, 32'h4000_0000, 5'd0, 8'h80, 8'h80, 8'h7F, 0, 1'b0);
      chk("single_word", got_q[0], 32'hB2B2_B2B2);
      chk("single_done_lat", done_cyc - hs_cyc[0], 1);

      // rounding
      cmem[16'h0050] = {32'd3, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF};
      run_job(16'h0050, 16'd1, 32'd0, 32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F, 0, 1'b0);
      chk("round_word", got_q[0], 32'h02FF_0100);

      // clamp high/low, then a raised floor
      cmem[16'h0060] = {32'd1000, 32'hFFFF_FC18, 32'd0, 32'd0};
      run_job(16'h0060, 16'd1, 32'd0, 32'h4000_0000, 5'd0, 8'h80, 8'h80, 8'h7F, 0, 1'b0);
      chk("clamp_word", got_q[0], 32'h7F80_8080);
      cmem[16'h0061] = {32'hFFFF_FFF6, 32'd10, 32'd0, 32'd0};
      run_job(16'h0061, 16'd1, 32'd0, 32'h4000_0000, 5'd0, 8'h00, 8'h00, 8'h7F, 0, 1'b0);
      chk("clamp_floor_word", got_q[0], 32'h0005_0000);

      // wrapping burst at full rate
      fill_rand(16'hFFF8, 16);
      run_job(16'hFFF8, 16'd16, 32'($urandom_range(0, 2000)) - 32'd1000, $urandom,
              5'($urandom_range(0, 8)), 8'hF6, 8'h80, 8'h7F, 0, 1'b0);
      chk("burst_first_lat", first_val_cyc - first_rd_cyc, 3);
      chk("burst_back_to_back", hs_cyc[15] - hs_cyc[0], 15);

      // backpressure with an ignored start mid-job
      fill_rand(16'h0100, 10);
      run_job(16'h0100, 16'd10, 32'd37, 32'h2345_6789, 5'd2, 8'h03, 8'hC0, 8'h50, 1, 1'b1);
      chk("bp_outstanding_ok", max_outst <= 4, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("bp_idle_busy", busy, 0);
      chk("bp_idle_valid", out_valid, 0);

      // empty job
      run_job(16'h0200, 16'd0, 32'd0, 32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F, 0, 1'b0);
      chk("empty_no_reads", rd_cnt, 0);
      chk("empty_done_lat", done_cyc - start_cyc, 3);

      // reset mid-burst, then a fresh job
      begin
         int d0;
         fill_rand(16'h0300, 16);
         push_exp(16'h0300, 16, 32'd5, 32'h3000_0000, 5'd1, 8'h00, 8'h80, 8'h7F);
         @(posedge clk); #1;
         set_job(16'h0300, 16'd16, 32'd5, 32'h3000_0000, 5'd1, 8'h00, 8'h80, 8'h7F);
         start = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         chk("pre_reset_valid", out_valid, 1);
         reset = 1'b1;
         #1;
         chk("mid_rst_valid", out_valid, 0);
         chk("mid_rst_busy", busy, 0);
         chk("mid_rst_rd_en", c_rd_en, 0);
         exp_q.delete();
         d0 = done_cnt;
         repeat (2) @(posedge clk);
         #1;
         reset = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         chk("mid_rst_no_done", done_cnt, d0);
         chk("mid_rst_idle_busy", busy, 0);
      end
      fill_rand(16'h0400, 5);
      run_job(16'h0400, 16'd5, 32'hFFFF_FF00, 32'h6000_0000, 5'd3, 8'h10, 8'h90, 8'h70, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/c_requant_unit.md
Name: c_requant_unit

Overview:
Downstream consumer of the TPU result buffer (C buffer, 128-bit rows of four int32 accumulators). After a matmul job it streams a contiguous range of C rows and applies per-job bias, fixed-point multiplier, rounding right shift, output offset and activation clamp to each lane. It packs each row's four int8 results into one 32-bit word and emits it on a valid/ready stream toward the CPU-side write-back path. It owns the C buffer read port while busy; the CFU muxes it the same way it muxes the TPU.

Parameters:
C_ADDR_BITS, 16, width of C buffer row index and of base/count
C_DATA_BITS, 128, C row width (fixed at 4 x 32-bit lanes)
FIFO_DEPTH, 4, output FIFO entries (power of two, >= 4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle job request; accepted only in IDLE
base  in  C_ADDR_BITS  first C row index
count  in  C_ADDR_BITS  number of rows to process (0 allowed)
bias  in  32  signed bias added to every lane
mult  in  32  signed Q31 multiplier
shift  in  5  extra right shift (0..31)
out_offset  in  8  signed output zero point
act_min  in  8  signed clamp low
act_max  in  8  signed clamp high (act_min <= act_max guaranteed by software)
c_rd_en  out  1  C buffer read enable
c_index  out  C_ADDR_BITS  C buffer row address
c_data_out  in  C_DATA_BITS  C buffer read data, valid 1 cycle after c_rd_en
out_valid  out  1  packed word available
out_ready  in  1  consumer accepts word
out_data  out  32  packed int8 x4
out_index  out  C_ADDR_BITS  row index the word came from
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after last word accepted

Behaviour:
- Reset values: c_rd_en=0, c_index=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0; FSM=IDLE; FIFO empty; in-flight count 0.
- Reset mid-job: immediate abort. FIFO, pipeline and counters are cleared. No done pulse.
- FSM: IDLE -> RUN on start (all job inputs latched; busy=1 next cycle). RUN -> DRAIN when the count-th read has issued. DRAIN -> DONE when the FIFO is empty and in-flight is 0. DONE -> IDLE after one cycle with done=1 and busy=0.
- count=0: IDLE -> RUN -> DRAIN -> DONE with no reads. done pulses 3 cycles after start.
- start while busy: ignored. Latched job fields do not change.
- Read issue in RUN: c_rd_en=1, c_index=base+k (k=0..count-1, wraps mod 2^C_ADDR_BITS) when in_flight + fifo_count < FIFO_DEPTH. Max one read per cycle.
- Pipeline: S0 BRAM read (1 cycle) -> S1 bias add + 32x32 signed multiply (registered) -> S2 round/shift/offset/clamp/pack -> FIFO write. Latency from c_rd_en to out_valid is 3 cycles with an empty FIFO. Throughput is 1 word/cycle with out_ready held high.
- Lane order: lane0=c_data_out[127:96], lane1=[95:64], lane2=[63:32], lane3=[31:0]. Packing: out_data[31:24]=lane0 ... out_data[7:0]=lane3.
- Per-lane arithmetic:
  - a = lane + bias, 32-bit two's-complement wrap.
  - p = a * mult, 64-bit signed.
  - r = (p + 2^(30+shift)) >>> (31+shift), arithmetic shift, round half up.
  - v = r + out_offset, computed at >= 34 bits.
  - result = clamp(v, act_min, act_max), truncated to 8 bits.
- Stream: out_valid = FIFO non-empty. A word transfers when out_valid && out_ready. out_data/out_index hold stable while out_valid && !out_ready. The credit check guarantees the FIFO never overflows; no data loss under any backpressure.
- Simultaneous FIFO push and pop: count unchanged, both take effect.
- done asserts only after the final word's handshake. Words are emitted strictly in index order.

Test Plan:
- Single row, count=1: all lanes 100, bias=0, mult=0x40000000, shift=0, offset=-128, min=-128, max=127 -> out_data=0xB2B2B2B2, out_index=base; done 1 cycle after handshake.
- Rounding row {3, -3, 1, -1}, mult=0x40000000, shift=0, offset=0 -> lanes {2, -1, 1, 0} -> out_data=0x02FF0100.
- Clamp: lane=1000, mult=0x40000000, offset=-128, max=127 -> 0x7F; lane=-1000, min=-128 -> 0x80; with act_min=0, lane=-10 -> 0x00.
- Burst count=16, base=0xFFF8, out_ready=1 -> 16 words on consecutive cycles, indices wrap 0xFFF8..0x0007, 3-cycle first latency.
- Backpressure: count=10, out_ready toggled 1-in-3 -> all 10 words in order, values match model, no more than FIFO_DEPTH outstanding reads+entries.
- count=0 -> no c_rd_en, done 3 cycles after start. start during busy ignored. Reset asserted mid-burst -> out_valid=0 and busy=0 immediately; a new job afterwards runs correctly.
